// File: rtl/mac_pkg.sv
// ============================================================================
// mac_pkg
// Shared constants and helpers for the precision-scalable MAC accumulator:
// precision-level encodings, lane geometry per level, drain FSM states.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mac_pkg;

  localparam int ACC_W = 56;
  localparam int OUT_W = 8;

  // prec_level encodings
  localparam logic [1:0] PREC_FULL = 2'b00;
  localparam logic [1:0] PREC_W4   = 2'b01;
  localparam logic [1:0] PREC_W2   = 2'b10;
  localparam logic [1:0] PREC_BAD  = 2'b11;

  // Lane count per level
  localparam int LANES_FULL = 1;
  localparam int LANES_W4   = 2;
  localparam int LANES_W2   = 4;

  // Lane width per level
  localparam int LW_FULL = 56;
  localparam int LW_W4   = 28;
  localparam int LW_W2   = 14;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } drain_state_t;

  // Index of the final lane for a level; the illegal level never drains.
  function automatic logic [1:0] last_lane_idx(input logic [1:0] prec);
    case (prec)
      PREC_W4: return 2'(LANES_W4 - 1);
      PREC_W2: return 2'(LANES_W2 - 1);
      default: return 2'(LANES_FULL - 1);
    endcase
  endfunction

  // Largest useful right shift for a level (LW-1).
  function automatic logic [5:0] max_shift(input logic [1:0] prec);
    case (prec)
      PREC_W4: return 6'(LW_W4 - 1);
      PREC_W2: return 6'(LW_W2 - 1);
      default: return 6'(LW_FULL - 1);
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lane_requant.sv
// ============================================================================
// lane_requant
// Combinational requantizer: round-half-up, arithmetic right shift and
// saturation of one sign-extended accumulator lane to a signed OUT_W value.
// Optional macro MAC_DRAIN_RELU_EN clamps negative results to zero.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lane_requant #(
  parameter int ACC_W = 56,
  parameter int OUT_W = 8,
  parameter int SH_W  = 6
) (
  input  logic [ACC_W-1:0] lane_val,
  input  logic [SH_W-1:0]  shift,
  output logic [OUT_W-1:0] result
);

  // One extra bit of headroom so the rounding increment cannot overflow.
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - (ACC_W+1)'(1);

  logic signed [ACC_W:0] ext;
  logic signed [ACC_W:0] inc;
  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] shifted;

  // Round, shift, optionally rectify, then saturate.
  always_comb begin
    ext = signed'({lane_val[ACC_W-1], lane_val});
    inc = '0;
    if (shift != '0) begin
      inc = (ACC_W+1)'(1) << (shift - SH_W'(1));
    end
    sum     = ext + inc;
    shifted = sum >>> shift;
`ifdef MAC_DRAIN_RELU_EN
    if (shifted[ACC_W]) begin
      shifted = '0;
    end
`endif
    if (shifted > SAT_MAX) begin
      result = SAT_MAX[OUT_W-1:0];
    end else if (shifted < SAT_MIN) begin
      result = SAT_MIN[OUT_W-1:0];
    end else begin
      result = shifted[OUT_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mac_result_drain.sv
// ============================================================================
// mac_result_drain
// Reader side of the MAC accumulator: captures one packed 56-bit word, splits
// it into 1/2/4 signed lanes by precision level and streams the requantized
// lanes one per valid/ready handshake. ACC_W must stay 56.
// Optional macro MAC_DRAIN_RELU_EN enables ReLU on the requantized output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mac_result_drain #(
  parameter int ACC_W = 56,
  parameter int OUT_W = 8,
  parameter int SH_W  = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       prec_level,
  input  logic [SH_W-1:0]  shamt,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_lane,
  output logic             out_last,
  output logic             busy,
  output logic             err_mode
);

  import mac_pkg::*;

  drain_state_t     state, next_state;
  logic [ACC_W-1:0] acc_q;
  logic [1:0]       prec_q;
  logic [SH_W-1:0]  sh_q;
  logic [1:0]       lane_idx;
  logic             accept;
  logic             advance;
  logic             lane_last;
  logic [ACC_W-1:0] lane_val;
  logic [SH_W-1:0]  lane_max_sh;
  logic [SH_W-1:0]  eff_sh;

  assign lane_last   = (lane_idx == last_lane_idx(prec_q));
  assign lane_max_sh = SH_W'(max_shift(prec_q));
  assign eff_sh      = (sh_q > lane_max_sh) ? lane_max_sh : sh_q;
  assign out_lane    = lane_idx;
  assign busy        = (state == ST_EMIT);

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Capture the word on acceptance, step the lane index, latch the error flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q    <= '0;
      prec_q   <= '0;
      sh_q     <= '0;
      lane_idx <= '0;
      err_mode <= 1'b0;
    end else if (accept) begin
      acc_q    <= in_acc;
      prec_q   <= prec_level;
      sh_q     <= shamt;
      lane_idx <= '0;
      if (prec_level == PREC_BAD) begin
        err_mode <= 1'b1;
      end
    end else if (advance) begin
      lane_idx <= lane_idx + 2'd1;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    accept     = 1'b0;
    advance    = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          // An illegal level is flagged and dropped without emitting.
          if (prec_level != PREC_BAD) begin
            next_state = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        out_last  = lane_last;
        if (out_ready) begin
          if (lane_last) begin
            next_state = ST_IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Select the current lane from the captured word and sign-extend it.
  always_comb begin
    lane_val = acc_q;
    case (prec_q)
      PREC_W4: begin
        if (lane_idx[0]) begin
          lane_val = {{(ACC_W-LW_W4){acc_q[2*LW_W4-1]}}, acc_q[2*LW_W4-1 -: LW_W4]};
        end else begin
          lane_val = {{(ACC_W-LW_W4){acc_q[LW_W4-1]}}, acc_q[LW_W4-1 -: LW_W4]};
        end
      end
      PREC_W2: begin
        case (lane_idx)
          2'd0:    lane_val = {{(ACC_W-LW_W2){acc_q[1*LW_W2-1]}}, acc_q[1*LW_W2-1 -: LW_W2]};
          2'd1:    lane_val = {{(ACC_W-LW_W2){acc_q[2*LW_W2-1]}}, acc_q[2*LW_W2-1 -: LW_W2]};
          2'd2:    lane_val = {{(ACC_W-LW_W2){acc_q[3*LW_W2-1]}}, acc_q[3*LW_W2-1 -: LW_W2]};
          default: lane_val = {{(ACC_W-LW_W2){acc_q[4*LW_W2-1]}}, acc_q[4*LW_W2-1 -: LW_W2]};
        endcase
      end
      default: lane_val = acc_q;
    endcase
  end

  lane_requant #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SH_W  (SH_W)
  ) u_requant (
    .lane_val (lane_val),
    .shift    (eff_sh),
    .result   (out_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_mac_result_drain.sv
// ============================================================================
// tb_mac_result_drain
// Self-checking bench for mac_result_drain: directed words, backpressure,
// illegal level, mid-drain reset, then randomized words against an
// arithmetic reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mac_result_drain;

  logic        clk;
  logic        rstn;
  logic [1:0]  prec_level;
  logic [5:0]  shamt;
  logic        in_valid;
  logic        in_ready;
  logic [55:0] in_acc;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_lane;
  logic        out_last;
  logic        busy;
  logic        err_mode;

  int checks   = 0;
  int failures = 0;
  logic err_exp = 1'b0;

  mac_result_drain #(.ACC_W(56), .OUT_W(8), .SH_W(6)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .prec_level (prec_level),
    .shamt      (shamt),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_acc     (in_acc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_lane   (out_lane),
    .out_last   (out_last),
    .busy       (busy),
    .err_mode   (err_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int n_lanes(input logic [1:0] prec);
    case (prec)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  // Reference: extract lane k, round half up, shift, (ReLU), saturate.
  function automatic logic [7:0] ref_lane(input logic [55:0] acc, input logic [1:0] prec,
                                          input logic [5:0] sh, input int k);
    int     lw;
    int     s;
    longint v;
    longint mask;
    lw   = (prec == 2'b01) ? 28 : (prec == 2'b10) ? 14 : 56;
    v    = longint'({8'd0, acc} >> (k * lw));
    mask = (64'sd1 <<< lw) - 64'sd1;
    v    = v & mask;
    if (v[lw-1]) v = v - (64'sd1 <<< lw);
    s = (int'(sh) > lw - 1) ? lw - 1 : int'(sh);
    if (s > 0) v = v + (64'sd1 <<< (s - 1));
    v = v >>> s;
`ifdef MAC_DRAIN_RELU_EN
    if (v < 0) v = 0;
`endif
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v[7:0];
  endfunction

  // Present one word and drain it. stall<0 picks a random 0..2 stall per lane.
  // With hold_in, in_valid stays high (carrying another word) during the drain.
  task automatic run_word(input logic [55:0] acc, input logic [1:0] prec, input logic [5:0] sh,
                          input int stall, input bit hold_in);
    int n;
    int st;
    logic [7:0] exp;
    check_eq("in_ready_idle", {63'd0, in_ready}, 64'd1);
    in_acc     = acc;
    prec_level = prec;
    shamt      = sh;
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    @(posedge clk); #1;
    // Scramble live inputs so any dependence on them shows up.
    in_acc     = ~acc;
    prec_level = 2'b00;
    shamt      = ~sh;
    if (!hold_in) in_valid = 1'b0;
    if (prec == 2'b11) begin
      err_exp = 1'b1;
      check_eq("bad_no_valid", {63'd0, out_valid}, 64'd0);
      check_eq("bad_in_ready", {63'd0, in_ready}, 64'd1);
      check_eq("bad_err_mode", {63'd0, err_mode}, 64'd1);
      return;
    end
    n = n_lanes(prec);
    for (int k = 0; k < n; k++) begin
      exp = ref_lane(acc, prec, sh, k);
      st  = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
      for (int j = 0; j < st; j++) begin
        out_ready = 1'b0;
        check_eq("stall_valid", {63'd0, out_valid}, 64'd1);
        check_eq("stall_in_ready", {63'd0, in_ready}, 64'd0);
        check_eq("stall_data", {56'd0, out_data}, {56'd0, exp});
        check_eq("stall_lane", {62'd0, out_lane}, 64'(k));
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      check_eq("lane_valid", {63'd0, out_valid}, 64'd1);
      check_eq("lane_busy", {63'd0, busy}, 64'd1);
      check_eq("lane_data", {56'd0, out_data}, {56'd0, exp});
      check_eq("lane_idx", {62'd0, out_lane}, 64'(k));
      check_eq("lane_last", {63'd0, out_last}, (k == n - 1) ? 64'd1 : 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_eq("done_valid", {63'd0, out_valid}, 64'd0);
    check_eq("done_busy", {63'd0, busy}, 64'd0);
    check_eq("done_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("done_err", {63'd0, err_mode}, {63'd0, err_exp});
  endtask

  logic [55:0] w;
  logic [1:0]  p;

  initial begin
    rstn       = 1'b0;
    prec_level = 2'b00;
    shamt      = 6'd0;
    in_valid   = 1'b0;
    in_acc     = 56'd0;
    out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_out_data", {56'd0, out_data}, 64'd0);
    check_eq("rst_out_lane", {62'd0, out_lane}, 64'd0);
    check_eq("rst_out_last", {63'd0, out_last}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_err", {63'd0, err_mode}, 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Full-width word, rounding with shift 3.
    run_word(56'd1000, 2'b00, 6'd3, 0, 1'b0);
    // Two 28-bit lanes: -16 and 300 (saturates).
    run_word({28'd300, 28'hFFFFFF0}, 2'b01, 6'd0, -1, 1'b0);
    // Four 14-bit lanes {64, -1, 5, -200}.
    w = {14'h3F38, 14'd5, 14'h3FFF, 14'd64};
    run_word(w, 2'b10, 6'd1, -1, 1'b0);
    // Backpressure for 5 cycles per lane with in_valid held high.
    run_word(w, 2'b10, 6'd1, 5, 1'b1);
    // Shift beyond lane width clamps to LW-1.
    run_word({14'h2000, 14'h1FFF, 14'd100, 14'h3000}, 2'b10, 6'd63, 0, 1'b0);
    run_word(56'h80_0000_0000_0000, 2'b00, 6'd60, 0, 1'b0);
    // Illegal level, then a normal word.
    run_word(56'h12345, 2'b11, 6'd2, 0, 1'b0);
    check_eq("err_sticky", {63'd0, err_mode}, 64'd1);
    run_word(56'd1000, 2'b00, 6'd3, 0, 1'b0);

    // Reset in the middle of a 4-lane drain.
    in_acc = w; prec_level = 2'b10; shamt = 6'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      check_eq("pre_rst_data", {56'd0, out_data}, {56'd0, ref_lane(w, 2'b10, 6'd1, k)});
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    rstn = 1'b0;
    #1;
    check_eq("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("mid_rst_busy", {63'd0, busy}, 64'd0);
    check_eq("mid_rst_lane", {62'd0, out_lane}, 64'd0);
    check_eq("mid_rst_last", {63'd0, out_last}, 64'd0);
    check_eq("mid_rst_data", {56'd0, out_data}, 64'd0);
    check_eq("mid_rst_err", {63'd0, err_mode}, 64'd0);
    err_exp = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    run_word({14'd7, 14'h3FF0, 14'd2000, 14'd33}, 2'b10, 6'd2, -1, 1'b0);

    // Randomized words.
    for (int i = 0; i < 150; i++) begin
      w = {24'($urandom), $urandom};
      p = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_word(w, p, 6'($urandom_range(0, 63)), -1, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
